contador_regressivo_n: RTL and testbench
========================================

// Module: contador_regressivo_n
// PURPOSE
//   Down-counting timer with a control FSM. It is the count-down counterpart of
//   the team's up/down counters. It loads a start value, decrements once every
//   PRESCALE clocks, flags the half-time point and pulses at terminal zero.
//   It serves as the round/response timeout timer in the SGA datapath, driven
//   by the unit controller.
// PARAMETERS
//   N            6      width of count value Q and load_val
//   DEFAULT_LOAD 10     start value used when load_val == 0; reload_reg value after reset
//   PRESCALE     1000   clocks per count step (>= 2)
// PORTS
//   clock      in   1   system clock, rising edge
//   clr        in   1   asynchronous reset, active-low
//   start      in   1   start / restart / resume request (level, sampled each clock)
//   pause      in   1   pause request
//   stop       in   1   abort to IDLE
//   auto_rld   in   1   1: reload and keep running at terminal count
//   load_val   in   N   start value, captured when start is accepted from IDLE/DONE
//   Q          out  N   current remaining count (registered)
//   running    out  1   state == RUN
//   paused     out  1   state == PAUSE
//   done       out  1   state == DONE
//   half_rco   out  1   (RUN or PAUSE) and Q == reload_reg/2 (integer division)
//   zero_rco   out  1   Q == 0
//   timeout    out  1   registered one-clock pulse at each terminal count
// BEHAVIOUR
//   Reset (clr=0, async): state=IDLE, Q=0, prescaler=0, reload_reg=DEFAULT_LOAD,
//     timeout=0. Outputs: running=paused=done=half_rco=0, zero_rco=1.
//   Control priority per clock: stop > start > pause.
//   States:
//     IDLE:  start -> RUN. reload_reg<=(load_val==0 ? DEFAULT_LOAD : load_val),
//            Q<=same value, prescaler<=0.
//     RUN:   stop -> IDLE, Q<=0.
//            pause -> PAUSE (prescaler and Q hold).
//            start -> restart: reload_reg and Q reloaded from load_val, prescaler<=0.
//     PAUSE: stop -> IDLE, Q<=0.
//            start -> RUN; resumes with no reload, prescaler continues from held value.
//            pause ignored.
//     DONE:  Q holds 0. start -> RUN with reload as from IDLE. stop -> IDLE.
//   Prescaler (RUN only): counts 0..PRESCALE-1 and wraps to 0. tick = (prescaler == PRESCALE-1).
//   On tick in RUN:
//     Q>1  -> Q<=Q-1.
//     Q==1 -> timeout<=1 for exactly one clock, then:
//       auto_rld=0: Q<=0 and state->DONE.
//       auto_rld=1: Q<=reload_reg and state stays RUN.
//   Latency: first decrement occurs PRESCALE clocks after the edge that accepted start.
//     The timeout pulse appears reload_reg*PRESCALE clocks after start.
//   Simultaneous events:
//     tick + pause in RUN: the decrement or terminal action is applied, then state->PAUSE.
//     A terminal tick with auto_rld=0 and pause goes to DONE, not PAUSE.
//     tick + stop: stop wins, no timeout pulse.
//     tick + start (RUN): restart wins, no timeout pulse.
//   Width: Q never underflows. Q=0 in RUN is unreachable, because a load of 0 maps to DEFAULT_LOAD.
//   Reset mid-RUN or mid-PAUSE aborts immediately to reset values. An in-flight timeout is cleared.
// TESTING
//   (PRESCALE=4, N=6, DEFAULT_LOAD=10 for all scenarios.)
//   1 Reset, then start with load_val=3, auto_rld=0:
//     Q=3 -> 2 -> 1 -> 0 at clocks 4, 8, 12 after start.
//     timeout high exactly 1 clock at clock 12, then done=1 and zero_rco=1.
//   2 load_val=0, start: Q=10 after start.
//     half_rco=1 only while Q=5.
//     timeout after 40 clocks.
//   3 load_val=2, auto_rld=1:
//     Q sequence 2, 1, 2, 1, ...
//     timeout pulses every 8 clocks; done stays 0.
//   4 load_val=5, pause at clock 6 for 10 clocks, then start:
//     Q holds 4 while paused; the remaining 2 prescaler clocks complete, so Q=3 two clocks after resume.
//   5 stop asserted on a tick clock with Q=1:
//     state=IDLE, Q=0, no timeout pulse.
//     Separately: clr=0 mid-count with no clock edge -> outputs reset immediately.
//   6 In RUN with Q=4, assert start with load_val=7:
//     Q=7, prescaler restarts, next decrement 4 clocks later.

Source files
------------

// File: rtl/contador_regressivo_n.sv
// Down-counting timer: loads a start value, steps down once every PRESCALE clocks,
// flags the half-time point and pulses timeout at each terminal count.
module contador_regressivo_n #(
    parameter int N            = 6,
    parameter int DEFAULT_LOAD = 10,
    parameter int PRESCALE     = 1000
) (
    input  logic         clock,
    input  logic         clr,
    input  logic         start,
    input  logic         pause,
    input  logic         stop,
    input  logic         auto_rld,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] Q,
    output logic         running,
    output logic         paused,
    output logic         done,
    output logic         half_rco,
    output logic         zero_rco,
    output logic         timeout
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_reload;
    logic [PW-1:0] r_presc;
    logic          r_timeout;

    logic          w_tick;
    logic [N-1:0]  w_load;
    logic [PW-1:0] w_presc_nxt;

    assign w_tick      = (r_presc == PW'(PRESCALE - 1));
    // A zero load would park RUN at Q=0, so it maps to the default start value.
    assign w_load      = (load_val == '0) ? N'(DEFAULT_LOAD) : load_val;
    assign w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            r_state   <= S_IDLE;
            r_q       <= '0;
            r_reload  <= N'(DEFAULT_LOAD);
            r_presc   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else if (start) begin
                        r_state  <= S_RUN;
                        r_reload <= w_load;
                        r_q      <= w_load;
                        r_presc  <= '0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_q     <= '0;
                        r_presc <= '0;
                    end else if (start) begin
                        r_reload <= w_load;
                        r_q      <= w_load;
                        r_presc  <= '0;
                    end else begin
                        r_presc <= w_presc_nxt;
                        if (pause) begin
                            r_state <= S_PAUSE;
                        end
                        // Terminal DONE is assigned last so it overrides a concurrent pause.
                        if (w_tick) begin
                            if (r_q > N'(1)) begin
                                r_q <= r_q - N'(1);
                            end else begin
                                r_timeout <= 1'b1;
                                if (auto_rld) begin
                                    r_q <= r_reload;
                                end else begin
                                    r_q     <= '0;
                                    r_state <= S_DONE;
                                end
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_q     <= '0;
                        r_presc <= '0;
                    end else if (start) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Q        = r_q;
    assign running  = (r_state == S_RUN);
    assign paused   = (r_state == S_PAUSE);
    assign done     = (r_state == S_DONE);
    assign half_rco = ((r_state == S_RUN) || (r_state == S_PAUSE)) && (r_q == (r_reload >> 1));
    assign zero_rco = (r_q == '0);
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_contador_regressivo_n.sv
// Bench for contador_regressivo_n with PRESCALE=4, N=6, DEFAULT_LOAD=10.
module tb_contador_regressivo_n;

    logic       clock = 1'b0;
    logic       clr;
    logic       start, pause, stop, auto_rld;
    logic [5:0] load_val;
    logic [5:0] Q;
    logic       running, paused, done, half_rco, zero_rco, timeout;

    int total = 0;
    int bad   = 0;

    contador_regressivo_n #(.N(6), .DEFAULT_LOAD(10), .PRESCALE(4)) dut (
        .clock    (clock),
        .clr      (clr),
        .start    (start),
        .pause    (pause),
        .stop     (stop),
        .auto_rld (auto_rld),
        .load_val (load_val),
        .Q        (Q),
        .running  (running),
        .paused   (paused),
        .done     (done),
        .half_rco (half_rco),
        .zero_rco (zero_rco),
        .timeout  (timeout)
    );

    always #5 clock = ~clock;

    // Inputs held for cyc clocks; outputs expected after the last of those edges.
    typedef struct {
        logic       st, ps, sp, ar;
        logic [5:0] lv;
        int         cyc;
        logic [5:0] q;
        logic       run, pau, dn, half, zero, tmo;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(logic st, logic ps, logic sp, logic ar, logic [5:0] lv, int cyc,
                                logic [5:0] q, logic run, logic pau, logic dn,
                                logic half, logic zero, logic tmo);
        vec_t v;
        v.st = st; v.ps = ps; v.sp = sp; v.ar = ar; v.lv = lv; v.cyc = cyc;
        v.q = q; v.run = run; v.pau = pau; v.dn = dn; v.half = half; v.zero = zero; v.tmo = tmo;
        return v;
    endfunction

    function automatic logic [11:0] outs();
        return {Q, running, paused, done, half_rco, zero_rco, timeout};
    endfunction

    task automatic check(string nm, logic [11:0] act, logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got Q=%0d r/p/d/h/z/t=%b want Q=%0d r/p/d/h/z/t=%b",
                     nm, act[11:6], act[5:0], exp[11:6], exp[5:0]);
        end
    endtask

    task automatic apply(vec_t v, int idx);
        vec_t e;
        start = v.st; pause = v.ps; stop = v.sp; auto_rld = v.ar; load_val = v.lv;
        sb.push_back(v);
        repeat (v.cyc) @(posedge clock);
        #1;
        e = sb.pop_front();
        check($sformatf("vec%0d", idx), outs(),
              {e.q, e.run, e.pau, e.dn, e.half, e.zero, e.tmo});
    endtask

    initial begin
        //                st ps sp ar lv cyc   Q run pau dn half zero tmo
        // load 3, single shot
        tbl.push_back(mk(1, 0, 0, 0, 3, 1,   3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,   3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4,   1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,   1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 1, 0));
        // load 0 -> default 10, timeout at 40 clocks
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  10, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 19,  6, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,   5, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,   5, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,   4, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 15,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1,   0, 0, 0, 0, 0, 1, 0));
        // load 2 with auto reload
        tbl.push_back(mk(1, 0, 0, 1, 2, 1,   2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 4,   1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3,   1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1,   2, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1,   2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 7,   2, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1,   2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1,   0, 0, 0, 0, 0, 1, 0));
        // load 5, pause mid-step, resume without reload, tick+pause, terminal tick+pause
        tbl.push_back(mk(1, 0, 0, 0, 5, 1,   5, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5,   4, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1,   4, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 9,   4, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 9, 1,   4, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,   4, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,   3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,   3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1,   2, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,   2, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4,   1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,   1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1,   0, 0, 0, 1, 0, 1, 1));
        // stop on the terminal tick: no timeout
        tbl.push_back(mk(1, 0, 0, 0, 1, 1,   1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,   1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1,   0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1, 0));
        // restart from RUN at Q=4, then restart on the terminal tick
        tbl.push_back(mk(1, 0, 0, 0, 4, 1,   4, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2,   4, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7, 1,   7, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,   7, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,   6, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 19,  2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,   1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  10, 1, 0, 0, 0, 0, 0));

        clr = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; auto_rld = 1'b0; load_val = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset", outs(), {6'd0, 6'b000010});
        clr = 1'b1;

        foreach (tbl[i]) apply(tbl[i], i);

        // Asynchronous reset between edges while counting
        start = 1'b0; pause = 1'b0; stop = 1'b0; auto_rld = 1'b0; load_val = '0;
        #2 clr = 1'b0;
        #1 check("async_clr_run", outs(), {6'd0, 6'b000010});
        #2 clr = 1'b1;

        // Asynchronous reset clears an in-flight timeout pulse
        @(posedge clock); #1;
        start = 1'b1; auto_rld = 1'b1; load_val = 6'd1;
        @(posedge clock); #1;
        start = 1'b0;
        check("arl1_start", outs(), {6'd1, 6'b100000});
        repeat (4) @(posedge clock);
        #1 check("arl1_pulse", outs(), {6'd1, 6'b100001});
        #2 clr = 1'b0;
        #1 check("async_clr_tmo", outs(), {6'd0, 6'b000010});
        #2 clr = 1'b1;
        auto_rld = 1'b0;
        @(posedge clock);
        #1 check("post_clr_idle", outs(), {6'd0, 6'b000010});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
